// File: rtl/blu_pkg.sv
// Shared definitions for the modular-reduction stage.
//   BLU_WIDTH : default coefficient width
//   BLU_Q     : default modulus
//   blu_stage_t : per-stage control carried alongside the data (valid + sign-fold flag)
//   blu_mu()  : Barrett constant floor(2^(2*width) / q)
package blu_pkg;

    localparam int unsigned BLU_WIDTH = 8;
    localparam int unsigned BLU_Q     = 251;

    typedef struct packed {
        logic valid;
        logic neg;
    } blu_stage_t;

    function automatic logic [63:0] blu_mu(input int unsigned width, input int unsigned q);
        return (64'd1 << (2 * width)) / 64'(q);
    endfunction

endpackage

// File: rtl/blu_mod_reduce_if.sv
// Handshake/data bundle between the butterfly unit and blu_mod_reduce.
//   in_valid_i/in_ready_o : input pair handshake
//   x_i, y_i              : butterfly sum (unsigned) and difference (two's complement)
//   out_valid_o/out_ready_i : reduced pair handshake
//   xr_o, yr_o            : reduced values in [0, Q)
// slave = reduction block, master = producer/consumer side.
interface blu_mod_reduce_if
    import blu_pkg::*;
#(
    parameter int unsigned WIDTH = BLU_WIDTH
);
    logic                 in_valid_i;
    logic                 in_ready_o;
    logic [2*WIDTH-1:0]   x_i;
    logic [2*WIDTH-1:0]   y_i;
    logic                 out_valid_o;
    logic                 out_ready_i;
    logic [WIDTH-1:0]     xr_o;
    logic [WIDTH-1:0]     yr_o;

    modport slave (
        input  in_valid_i, x_i, y_i, out_ready_i,
        output in_ready_o, out_valid_o, xr_o, yr_o
    );

    modport master (
        output in_valid_i, x_i, y_i, out_ready_i,
        input  in_ready_o, out_valid_o, xr_o, yr_o
    );
endinterface

// File: rtl/blu_barrett_core.sv
// Barrett reduction datapath, stages S2..S4, for a single value.
//   clk, rst : clock and synchronous active-high reset (clears the result register)
//   en       : advance all stages (low = hold)
//   v        : S1 value, unsigned 2*WIDTH bits
//   fold     : value currently in S3 was a folded negative; output Q - r (or 0)
//   r        : registered result in [0, Q)
module blu_barrett_core
    import blu_pkg::*;
#(
    parameter int unsigned WIDTH = BLU_WIDTH,
    parameter int unsigned Q     = BLU_Q
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic [2*WIDTH-1:0] v,
    input  logic               fold,
    output logic [WIDTH-1:0]   r
);
    localparam int unsigned VW = 2 * WIDTH;
    localparam int unsigned PW = 4 * WIDTH;
    // Barrett error is at most 2Q, so the raw remainder fits in WIDTH+2 bits.
    localparam int unsigned RW = WIDTH + 2;

    localparam logic [VW-1:0]    MU = VW'(blu_mu(WIDTH, Q));
    localparam logic [VW-1:0]    QV = VW'(Q);
    localparam logic [RW-1:0]    QR = RW'(Q);
    localparam logic [WIDTH-1:0] QW = WIDTH'(Q);

    logic [VW-1:0]    s2_v;
    logic [PW-1:0]    s2_prod;
    logic [VW-1:0]    q_est_c;
    logic [VW-1:0]    rem_c;
    logic [RW-1:0]    s3_r;
    logic [RW-1:0]    r1_c;
    logic [RW-1:0]    r2_c;
    logic [WIDTH-1:0] red_c;
    logic [WIDTH-1:0] out_c;

    // S2: full-width product v*MU, no truncation before the shift.
    always_ff @(posedge clk) begin
        if (en) begin
            s2_v    <= v;
            s2_prod <= PW'(v) * PW'(MU);
        end
    end

    // S3: r = v - q_est*Q; wrap-around in VW bits is harmless since r < 3Q.
    assign q_est_c = s2_prod[PW-1:VW];
    assign rem_c   = s2_v - q_est_c * QV;

    always_ff @(posedge clk) begin
        if (en) begin
            s3_r <= RW'(rem_c);
        end
    end

    // S4: two conditional subtractions, then undo the sign fold.
    always_comb begin
        r1_c  = (s3_r >= QR) ? s3_r - QR : s3_r;
        r2_c  = (r1_c >= QR) ? r1_c - QR : r1_c;
        red_c = WIDTH'(r2_c);
        out_c = (fold && (red_c != '0)) ? QW - red_c : red_c;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r <= '0;
        end else if (en) begin
            r <= out_c;
        end
    end

endmodule

// File: rtl/blu_mod_reduce.sv
// Four-stage pipelined Barrett reduction of a butterfly output pair modulo Q.
//   clk_i, rst_i : clock, synchronous active-high reset
//   bus (slave)  : input pair handshake (x_i, y_i) and reduced pair handshake (xr_o, yr_o)
//   cnt_o        : completed output transfers, 16-bit wrapping; present only when
//                  BLU_RED_STATS_EN is defined
// Stages: S1 register + sign fold, S2 multiply by MU, S3 subtract q_est*Q,
// S4 correction + output register. A stalled output freezes the whole pipe.
module blu_mod_reduce
    import blu_pkg::*;
#(
    parameter int unsigned WIDTH = BLU_WIDTH,
    parameter int unsigned Q     = BLU_Q
) (
    input  logic               clk_i,
    input  logic               rst_i,
    blu_mod_reduce_if.slave    bus
`ifdef BLU_RED_STATS_EN
    ,
    output logic [15:0]        cnt_o
`endif
);
    localparam int unsigned VW = 2 * WIDTH;

    logic          advance;
    logic          out_valid;
    blu_stage_t    s1;
    blu_stage_t    s2;
    blu_stage_t    s3;
    logic [VW-1:0] s1_x;
    logic [VW-1:0] s1_y;
    logic [VW-1:0] y_abs_c;
    logic [WIDTH-1:0] xr;
    logic [WIDTH-1:0] yr;

    // Single global stall: only a held output blocks the pipe.
    assign advance        = ~(out_valid & ~bus.out_ready_i);
    assign bus.in_ready_o = rst_i | advance;
    assign bus.out_valid_o = out_valid;
    assign bus.xr_o        = xr;
    assign bus.yr_o        = yr;

    // |y| in VW unsigned bits; the most negative value maps to 2^(VW-1).
    assign y_abs_c = bus.y_i[VW-1] ? (~bus.y_i + VW'(1)) : bus.y_i;

    // Stage control: valid bits and the fold flag travel with the data.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s1        <= '0;
            s2        <= '0;
            s3        <= '0;
            out_valid <= 1'b0;
        end else if (advance) begin
            s1.valid  <= bus.in_valid_i;
            s1.neg    <= bus.y_i[VW-1];
            s2        <= s1;
            s3        <= s2;
            out_valid <= s3.valid;
        end
    end

    // S1 data register.
    always_ff @(posedge clk_i) begin
        if (advance) begin
            s1_x <= bus.x_i;
            s1_y <= y_abs_c;
        end
    end

    blu_barrett_core #(.WIDTH(WIDTH), .Q(Q)) u_core_x (
        .clk  (clk_i),
        .rst  (rst_i),
        .en   (advance),
        .v    (s1_x),
        .fold (1'b0),
        .r    (xr)
    );

    blu_barrett_core #(.WIDTH(WIDTH), .Q(Q)) u_core_y (
        .clk  (clk_i),
        .rst  (rst_i),
        .en   (advance),
        .v    (s1_y),
        .fold (s3.neg),
        .r    (yr)
    );

`ifdef BLU_RED_STATS_EN
    // Completed output transfers, wrapping at 16 bits.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_o <= '0;
        end else if (out_valid && bus.out_ready_i) begin
            cnt_o <= cnt_o + 16'd1;
        end
    end
`endif

endmodule
